// File: rtl/dispatch_stall_ctrl.sv
// N-wide dispatch/fetch stall controller: per-cycle dispatch grant from backend
// free-slot counts, flush-recovery sequencing and saturating per-cause stall counters.
module dispatch_stall_ctrl #(
  parameter int DISPATCH_WIDTH  = 2,
  parameter int ROB_CNT_W       = 6,
  parameter int FL_CNT_W        = 7,
  parameter int IQ_CNT_W        = 5,
  parameter int RECOVERY_CYCLES = 2,
  parameter int PERF_W          = 32,
  localparam int GW = $clog2(DISPATCH_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [GW-1:0]        decode_valid_cnt,
  input  logic [ROB_CNT_W-1:0] rob_free_cnt,
  input  logic [FL_CNT_W-1:0]  fl_free_cnt,
  input  logic [IQ_CNT_W-1:0]  iq_free_cnt,
  output logic [GW-1:0]        dispatch_grant_cnt,
  output logic                 stall_dispatch,
  output logic                 stall_fetch,
  output logic                 pc_valid,
  output logic                 recovering,
  output logic [PERF_W-1:0]    perf_stall_rob,
  output logic [PERF_W-1:0]    perf_stall_fl,
  output logic [PERF_W-1:0]    perf_stall_iq
);

  localparam int CW   = $clog2(RECOVERY_CYCLES + 1);
  localparam int MW01 = (ROB_CNT_W > FL_CNT_W) ? ROB_CNT_W : FL_CNT_W;
  localparam int MW23 = (IQ_CNT_W > GW) ? IQ_CNT_W : GW;
  localparam int MW   = (MW01 > MW23) ? MW01 : MW23;

  typedef logic [MW-1:0] cnt_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, RESUME} state_t;

  function automatic cnt_t min2(input cnt_t a, input cnt_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction

  state_t            state_q, state_d;
  logic [CW-1:0]     drain_cnt_q, drain_cnt_d;
  logic [PERF_W-1:0] perf_rob_q, perf_fl_q, perf_iq_q;

  cnt_t          rob_x, fl_x, iq_x, dw_x, dec_x, avail_x, dv_x;
  logic          over;
  logic [GW-1:0] grant_run;

  // All counts are compared zero-extended to the widest operand; the result of
  // min() never exceeds DISPATCH_WIDTH, so the clamp to GW bits is lossless.
  assign rob_x   = cnt_t'(rob_free_cnt);
  assign fl_x    = cnt_t'(fl_free_cnt);
  assign iq_x    = cnt_t'(iq_free_cnt);
  assign dec_x   = cnt_t'(decode_valid_cnt);
  assign dw_x    = cnt_t'(DISPATCH_WIDTH);
  assign avail_x = min2(min2(dw_x, rob_x), min2(fl_x, iq_x));
  assign dv_x    = min2(dec_x, dw_x);
  assign over    = (dv_x > avail_x);
  assign grant_run = over ? avail_x[GW-1:0] : dv_x[GW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // A flush in any state (re)starts the drain window.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    if (flush) begin
      state_d     = DRAIN;
      drain_cnt_d = CW'(RECOVERY_CYCLES - 1);
    end else begin
      case (state_q)
        IDLE:   state_d = RUN;
        RUN:    state_d = RUN;
        DRAIN: begin
          if (drain_cnt_q == '0) state_d = RESUME;
          else                   drain_cnt_d = drain_cnt_q - CW'(1);
        end
        RESUME: state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    dispatch_grant_cnt = '0;
    stall_dispatch     = 1'b0;
    stall_fetch        = 1'b0;
    pc_valid           = 1'b0;
    recovering         = 1'b0;
    perf_stall_rob     = '0;
    perf_stall_fl      = '0;
    perf_stall_iq      = '0;
    if (!rst) begin
      recovering     = (state_q == DRAIN) || (state_q == RESUME);
      perf_stall_rob = perf_rob_q;
      perf_stall_fl  = perf_fl_q;
      perf_stall_iq  = perf_iq_q;
      if (flush) begin
        stall_dispatch = 1'b1;
      end else begin
        case (state_q)
          RUN: begin
            dispatch_grant_cnt = grant_run;
            stall_dispatch     = over;
            stall_fetch        = over;
            pc_valid           = !over;
          end
          DRAIN: begin
            stall_dispatch = 1'b1;
            stall_fetch    = 1'b1;
          end
          // Redirected PC is fetched while dispatch stays empty.
          RESUME: begin
            stall_dispatch = 1'b1;
            pc_valid       = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // One cause per stalled cycle, ROB first, then free list, then issue queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_rob_q <= '0;
      perf_fl_q  <= '0;
      perf_iq_q  <= '0;
    end else if ((state_q == RUN) && !flush && over) begin
      if (rob_x < dv_x)     perf_rob_q <= sat_inc(perf_rob_q);
      else if (fl_x < dv_x) perf_fl_q  <= sat_inc(perf_fl_q);
      else                  perf_iq_q  <= sat_inc(perf_iq_q);
    end
  end

endmodule

// File: tb/tb_dispatch_stall_ctrl.sv
// Directed bench for dispatch_stall_ctrl (DISPATCH_WIDTH=2, RECOVERY_CYCLES=2, PERF_W=4).
module tb_dispatch_stall_ctrl;
  localparam int GW = 2;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst, flush;
  logic [GW-1:0] dec;
  logic [5:0]    rob;
  logic [6:0]    fl;
  logic [4:0]    iq;
  logic [GW-1:0] grant;
  logic          sd, sf, pv, rec;
  logic [PW-1:0] p_rob, p_fl, p_iq;
  logic [GW+3:0] ov;
  logic [PW-1:0] e_rob, e_fl, e_iq;
  int checks = 0;
  int errors = 0;

  dispatch_stall_ctrl #(
    .DISPATCH_WIDTH(2), .ROB_CNT_W(6), .FL_CNT_W(7), .IQ_CNT_W(5),
    .RECOVERY_CYCLES(2), .PERF_W(PW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .decode_valid_cnt(dec),
    .rob_free_cnt(rob), .fl_free_cnt(fl), .iq_free_cnt(iq),
    .dispatch_grant_cnt(grant), .stall_dispatch(sd), .stall_fetch(sf),
    .pc_valid(pv), .recovering(rec),
    .perf_stall_rob(p_rob), .perf_stall_fl(p_fl), .perf_stall_iq(p_iq)
  );

  // {grant, stall_dispatch, stall_fetch, pc_valid, recovering}
  assign ov = {grant, sd, sf, pv, rec};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int d, input int r, input int f, input int q);
    dec = GW'(d);
    rob = 6'(r);
    fl  = 7'(f);
    iq  = 5'(q);
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; set_in(2, 8, 8, 8);
    e_rob = '0; e_fl = '0; e_iq = '0;
    tick; tick; #1;
    checks++;
    if (ov !== 6'b0 || {p_rob, p_fl, p_iq} !== '0) begin
      errors++;
      $display("FAIL reset_hold: outputs=%b perf=%h required 000000 / 000", ov, {p_rob, p_fl, p_iq});
    end
    rst = 1'b0; #1;
    checks++;
    if (ov !== {2'd0, 4'b0000}) begin
      errors++; $display("FAIL idle_cycle: got %b required %b", ov, {2'd0, 4'b0000});
    end
    tick; #1;
    checks++;
    if (ov !== {2'd2, 4'b0010}) begin
      errors++; $display("FAIL first_run: got %b required %b", ov, {2'd2, 4'b0010});
    end
    tick;
  endtask

  task automatic test_rob_stall;
    set_in(2, 1, 8, 8);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ov !== {2'd1, 4'b1100}) begin
        errors++; $display("FAIL rob_stall_out[%0d]: got %b required %b", i, ov, {2'd1, 4'b1100});
      end
      tick;
      e_rob++;
      checks++;
      if ({p_rob, p_fl, p_iq} !== {e_rob, e_fl, e_iq}) begin
        errors++; $display("FAIL rob_perf[%0d]: got %h required %h", i, {p_rob, p_fl, p_iq}, {e_rob, e_fl, e_iq});
      end
    end
  endtask

  task automatic test_fl_stall;
    set_in(2, 4, 0, 0);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (ov !== {2'd0, 4'b1100}) begin
        errors++; $display("FAIL fl_stall_out[%0d]: got %b required %b", i, ov, {2'd0, 4'b1100});
      end
      tick;
      e_fl++;
      checks++;
      if ({p_rob, p_fl, p_iq} !== {e_rob, e_fl, e_iq}) begin
        errors++; $display("FAIL fl_perf[%0d]: got %h required %h", i, {p_rob, p_fl, p_iq}, {e_rob, e_fl, e_iq});
      end
    end
  endtask

  task automatic test_boundaries;
    set_in(0, 0, 0, 0); #1;
    checks++;
    if (ov !== {2'd0, 4'b0010}) begin
      errors++; $display("FAIL zero_dv: got %b required %b", ov, {2'd0, 4'b0010});
    end
    tick;
    checks++;
    if ({p_rob, p_fl, p_iq} !== {e_rob, e_fl, e_iq}) begin
      errors++; $display("FAIL zero_dv_perf: got %h required %h", {p_rob, p_fl, p_iq}, {e_rob, e_fl, e_iq});
    end
    set_in(3, 8, 8, 8); #1;
    checks++;
    if (ov !== {2'd2, 4'b0010}) begin
      errors++; $display("FAIL dv_clamp: got %b required %b", ov, {2'd2, 4'b0010});
    end
    tick;
    set_in(2, 0, 8, 8); #1;
    checks++;
    if (ov !== {2'd0, 4'b1100}) begin
      errors++; $display("FAIL full_stall: got %b required %b", ov, {2'd0, 4'b1100});
    end
    tick;
    e_rob++;
    checks++;
    if ({p_rob, p_fl, p_iq} !== {e_rob, e_fl, e_iq}) begin
      errors++; $display("FAIL full_stall_perf: got %h required %h", {p_rob, p_fl, p_iq}, {e_rob, e_fl, e_iq});
    end
  endtask

  task automatic test_flush;
    // Flush while the ROB is full: the cycle must not be attributed as a stall.
    set_in(2, 0, 8, 8); flush = 1'b1; #1;
    checks++;
    if (ov !== {2'd0, 4'b1000}) begin
      errors++; $display("FAIL flush_cycle: got %b required %b", ov, {2'd0, 4'b1000});
    end
    tick;
    flush = 1'b0; set_in(2, 8, 8, 8);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (ov !== {2'd0, 4'b1101}) begin
        errors++; $display("FAIL drain[%0d]: got %b required %b", i, ov, {2'd0, 4'b1101});
      end
      tick;
    end
    #1;
    checks++;
    if (ov !== {2'd0, 4'b1011}) begin
      errors++; $display("FAIL resume: got %b required %b", ov, {2'd0, 4'b1011});
    end
    tick; #1;
    checks++;
    if (ov !== {2'd2, 4'b0010} || {p_rob, p_fl, p_iq} !== {e_rob, e_fl, e_iq}) begin
      errors++; $display("FAIL flush_back_to_run: got %b/%h required %b/%h", ov, {p_rob, p_fl, p_iq}, {2'd2, 4'b0010}, {e_rob, e_fl, e_iq});
    end
    tick;
  endtask

  task automatic test_flush_restart;
    flush = 1'b1; tick;
    flush = 1'b0; #1;
    checks++;
    if (ov !== {2'd0, 4'b1101}) begin
      errors++; $display("FAIL restart_drain1: got %b required %b", ov, {2'd0, 4'b1101});
    end
    tick;
    flush = 1'b1; #1;
    checks++;
    if (ov !== {2'd0, 4'b1001}) begin
      errors++; $display("FAIL restart_reflush: got %b required %b", ov, {2'd0, 4'b1001});
    end
    tick;
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (ov !== {2'd0, 4'b1101}) begin
        errors++; $display("FAIL restart_drain[%0d]: got %b required %b", i, ov, {2'd0, 4'b1101});
      end
      tick;
    end
    #1;
    checks++;
    if (ov !== {2'd0, 4'b1011}) begin
      errors++; $display("FAIL restart_resume: got %b required %b", ov, {2'd0, 4'b1011});
    end
    tick; #1;
    checks++;
    if (ov !== {2'd2, 4'b0010}) begin
      errors++; $display("FAIL restart_run: got %b required %b", ov, {2'd2, 4'b0010});
    end
    tick;
  endtask

  task automatic test_iq_saturation;
    set_in(2, 8, 8, 1); #1;
    checks++;
    if (ov !== {2'd1, 4'b1100}) begin
      errors++; $display("FAIL iq_stall_out: got %b required %b", ov, {2'd1, 4'b1100});
    end
    // 14 cycles reach 2^PW-2, then 3 more must pin at all-ones.
    for (int i = 0; i < 17; i++) begin
      tick;
      if (e_iq != '1) e_iq++;
      checks++;
      if ({p_rob, p_fl, p_iq} !== {e_rob, e_fl, e_iq}) begin
        errors++; $display("FAIL iq_perf[%0d]: got %h required %h", i, {p_rob, p_fl, p_iq}, {e_rob, e_fl, e_iq});
      end
    end
    rst = 1'b1; #1;
    checks++;
    if (ov !== 6'b0 || p_iq !== '0) begin
      errors++; $display("FAIL rst_mid_stall: got %b/%h required 000000/0", ov, p_iq);
    end
    tick;
    rst = 1'b0; e_rob = '0; e_fl = '0; e_iq = '0; #1;
    checks++;
    if (ov !== {2'd0, 4'b0000} || {p_rob, p_fl, p_iq} !== '0) begin
      errors++; $display("FAIL post_rst_idle: got %b/%h required %b/000", ov, {p_rob, p_fl, p_iq}, {2'd0, 4'b0000});
    end
    tick; #1;
    checks++;
    if (ov !== {2'd1, 4'b1100}) begin
      errors++; $display("FAIL post_rst_run: got %b required %b", ov, {2'd1, 4'b1100});
    end
    tick;
    e_iq++;
    checks++;
    if ({p_rob, p_fl, p_iq} !== {e_rob, e_fl, e_iq}) begin
      errors++; $display("FAIL post_rst_perf: got %h required %h", {p_rob, p_fl, p_iq}, {e_rob, e_fl, e_iq});
    end
  endtask

  initial begin
    test_reset;
    test_rob_stall;
    test_fl_stall;
    test_boundaries;
    test_flush;
    test_flush_restart;
    test_iq_saturation;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dispatch_stall_ctrl.md
Name: dispatch_stall_ctrl

Overview:
Parametrised, N-wide successor to the single-bit fetch/dispatch stall controller in the out-of-order core.
- Computes each cycle how many decoded instructions may dispatch, from free-slot counts of the ROB, the physical-register free list and the issue queue.
- Runs a flush-recovery state machine that holds the front end for a programmable number of cycles after a flush.
- Keeps saturating per-cause stall-cycle counters for performance analysis.

Parameters:
DISPATCH_WIDTH, 2, maximum instructions dispatched per cycle (>=1)
ROB_CNT_W, 6, width of rob_free_cnt
FL_CNT_W, 7, width of fl_free_cnt
IQ_CNT_W, 5, width of iq_free_cnt
RECOVERY_CYCLES, 2, cycles the front end is held in DRAIN after a flush (>=1)
PERF_W, 32, width of each performance counter
Local: GW = $clog2(DISPATCH_WIDTH+1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
flush  in  1  pipeline flush (mispredict or exception), one or more cycles
decode_valid_cnt  in  GW  number of valid instructions at the decode/dispatch boundary
rob_free_cnt  in  ROB_CNT_W  free ROB entries
fl_free_cnt  in  FL_CNT_W  free physical registers
iq_free_cnt  in  IQ_CNT_W  free issue-queue entries
dispatch_grant_cnt  out  GW  instructions allowed to dispatch this cycle
stall_dispatch  out  1  dispatch cannot take all valid instructions
stall_fetch  out  1  fetch must hold its PC and fetch buffer
pc_valid  out  1  fetch may issue a new PC this cycle
recovering  out  1  state is DRAIN or RESUME
perf_stall_rob  out  PERF_W  stall cycles attributed to the ROB
perf_stall_fl  out  PERF_W  stall cycles attributed to the free list
perf_stall_iq  out  PERF_W  stall cycles attributed to the issue queue

Behaviour:
- States: IDLE, RUN, DRAIN, RESUME. Registered drain counter, width $clog2(RECOVERY_CYCLES+1).
- rst (highest priority):
  - state <= IDLE; counter and all perf counters <= 0.
  - While rst is high, all outputs are forced to 0 combinationally.
- Transitions:
  - IDLE -> RUN unconditionally on the next cycle.
  - Any state with flush=1 -> DRAIN, counter <= RECOVERY_CYCLES-1. A flush during DRAIN or RESUME restarts the count.
  - DRAIN: counter decrements each cycle; at 0 with no flush -> RESUME.
  - RESUME -> RUN after one cycle.
- Grant, evaluated combinationally every cycle:
  - avail = min(DISPATCH_WIDTH, rob_free_cnt, fl_free_cnt, iq_free_cnt). Comparisons zero-extend to the widest operand, then clamp to GW bits.
  - dv = min(decode_valid_cnt, DISPATCH_WIDTH).
  - In RUN: dispatch_grant_cnt = min(dv, avail). In all other states: 0.
- Stall outputs:
  - RUN: stall_dispatch = stall_fetch = (dv > avail); pc_valid = !stall_fetch.
  - IDLE: pc_valid=0, stall_fetch=0, stall_dispatch=0.
  - DRAIN: pc_valid=0, stall_fetch=1, stall_dispatch=1.
  - RESUME: pc_valid=1, stall_fetch=0, stall_dispatch=1, so the redirected PC is fetched while dispatch stays empty.
  - flush=1 in any state forces pc_valid=0, stall_fetch=0, stall_dispatch=1 and grant=0 in that cycle. This overrides the RUN equations.
- recovering = (state==DRAIN || state==RESUME).
- Perf attribution, only in RUN with flush=0 and dv > avail. Exactly one counter increments, by priority:
  - ROB if rob_free_cnt < dv;
  - else free list if fl_free_cnt < dv;
  - else issue queue.
  - Counters saturate at all-ones. flush does not clear them.
- dv = 0 never stalls: grant=0, stall=0, pc_valid=1 in RUN.
- Zero free entries with dv > 0 gives a full stall, identical to the single-bit full/empty behaviour.

Test Plan:
- Reset, then DW=2, dv=2, all counts 8 → cycle 0 after reset IDLE: pc_valid=0, grant=0; cycle 1 RUN: grant=2, pc_valid=1, stalls=0.
- RUN, dv=2, rob_free=1, fl_free=8, iq_free=8 → grant=1, stall_dispatch=1, stall_fetch=1, pc_valid=0; perf_stall_rob increments by 1 per cycle; the others hold.
- RUN, dv=2, rob_free=4, fl_free=0, iq_free=0 → grant=0; only perf_stall_fl increments (priority over IQ).
- One-cycle flush in RUN with RECOVERY_CYCLES=2:
  - Flush cycle: pc_valid=0, stall_dispatch=1, grant=0.
  - Next 2 cycles DRAIN: recovering=1, stall_fetch=1.
  - Then 1 cycle RESUME: pc_valid=1, stall_dispatch=1.
  - Then RUN with normal grant.
- Flush reasserted in the second DRAIN cycle → DRAIN restarts; a full 2 DRAIN cycles follow the last flush before RESUME.
- Preload perf_stall_iq to 2^PERF_W-2 (force or PERF_W=4 build) and hold an IQ stall for 3 cycles → saturates at all-ones; rst mid-stall clears it to 0 and returns to IDLE next cycle.
